// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg: shared widths and the fetch entry layout for the instruction buffer
//   N        : bundle width (fetch enqueue / decode dequeue lanes)
//   IB_DEPTH : default buffer depth in entries
package instr_buffer_pkg;
  localparam int N = 3;
  localparam int IB_DEPTH = 16;
  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct packed {
    logic [31:0] inst;
    addr_t pc;
    logic is_branch;
    logic bp_pred_taken;
    addr_t bp_pred_target;
    logic [7:0] bp_ghr_snapshot;
  } fetch_entry_t;
endpackage

// File: rtl/instr_buffer_if.sv
// instr_buffer_if: fetch/decode/redirect signals around the instruction buffer
//   master : fetch + decode + EX side (drives bundle, take, redirect)
//   slave  : the buffer (drives stall, decode lanes, occupancy)
interface instr_buffer_if import instr_buffer_pkg::*; #(parameter int DEPTH = IB_DEPTH);
  logic ib_bundle_valid_i;
  fetch_entry_t [N-1:0] ib_fetch_i;
  logic ib_stall_o;
  logic ex_redirect_valid_i;
  logic [N-1:0] id_valid_o;
  fetch_entry_t [N-1:0] id_entry_o;
  logic [$clog2(N+1)-1:0] id_take_i;
  logic [$clog2(DEPTH+1)-1:0] ib_count_o;
  modport master (
    output ib_bundle_valid_i, ib_fetch_i, ex_redirect_valid_i, id_take_i,
    input ib_stall_o, id_valid_o, id_entry_o, ib_count_o
  );
  modport slave (
    input ib_bundle_valid_i, ib_fetch_i, ex_redirect_valid_i, id_take_i,
    output ib_stall_o, id_valid_o, id_entry_o, ib_count_o
  );
endinterface

// File: rtl/instr_buffer.sv
// instr_buffer: circular FIFO absorbing N-wide fetch bundles, presenting the N oldest to decode
//   clock : rising-edge clock
//   reset : synchronous active-low, clears pointers and occupancy (array kept)
//   ib    : slave side of instr_buffer_if (bundle in, stall out, decode lanes out, take in, redirect in)
module instr_buffer import instr_buffer_pkg::*; #(
  parameter int DEPTH = IB_DEPTH
) (
  input logic clock,
  input logic reset,
  instr_buffer_if.slave ib
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * N) begin : g_bad_depth
    $error("instr_buffer: DEPTH must be a power of two and at least 2*N");
  end
  fetch_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, req, take;
  logic enq;
  // stall looks only at the registered count, so decode's take never reaches fetch combinationally
  assign ib.ib_stall_o = count > CW'(DEPTH - N);
  assign enq = reset && ib.ib_bundle_valid_i && !ib.ib_stall_o && !ib.ex_redirect_valid_i;
  assign req = CW'(ib.id_take_i) > CW'(N) ? CW'(N) : CW'(ib.id_take_i);
  assign take = req > count ? count : req;
  assign ib.ib_count_o = count;
  // pointers are exactly log2(DEPTH) wide so adds wrap modulo DEPTH on their own
  always_ff @(posedge clock) begin
    if (!reset || ib.ex_redirect_valid_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(take);
      if (enq) tail <= tail + PW'(N);
      count <= count + (enq ? CW'(N) : '0) - take;
    end
  end
  always_ff @(posedge clock)
    if (enq)
      for (int i = 0; i < N; i++)
        entries[tail + PW'(i)] <= ib.ib_fetch_i[i];
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign ib.id_valid_o[i] = count > CW'(i);
    assign ib.id_entry_o[i] = entries[head + PW'(i)];
  end
  always_ff @(posedge clock)
    if (reset) begin
      assert (count <= CW'(DEPTH));
      assert (PW'(tail - head) == count[PW-1:0]);
    end
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: queue-model scoreboard for instr_buffer with directed and random traffic
module tb_instr_buffer;
  import instr_buffer_pkg::*;
  localparam int D = 16;
  localparam int TW = $clog2(N+1);
  typedef struct {
    int cnt;
    bit stall;
    logic [N-1:0] vld;
    fetch_entry_t e [N];
  } exp_t;
  logic clk = 0;
  logic rst_n;
  always #5 clk = ~clk;
  instr_buffer_if #(.DEPTH(D)) ib ();
  instr_buffer #(.DEPTH(D)) dut (.clock(clk), .reset(rst_n), .ib(ib.slave));
  fetch_entry_t mq [$];
  exp_t exp_q [$];
  exp_t x;
  fetch_entry_t bundle [N];
  addr_t pc;
  int vectors = 0, miscompares = 0;

  task automatic chk(string name, logic [127:0] got, logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic make_bundle();
    for (int i = 0; i < N; i++) begin
      bundle[i].pc = pc + addr_t'(4 * i);
      bundle[i].inst = $urandom;
      bundle[i].is_branch = 1'($urandom);
      bundle[i].bp_pred_taken = 1'($urandom);
      bundle[i].bp_pred_target = $urandom;
      bundle[i].bp_ghr_snapshot = 8'($urandom);
      ib.ib_fetch_i[i] = bundle[i];
    end
  endtask

  // one clock: publish expectation for this cycle, drive inputs, then advance the FIFO model
  task automatic cyc(bit v, int t, bit r, bit rs);
    exp_t e;
    int tk;
    bit st;
    e.cnt = mq.size();
    e.stall = (D - e.cnt) < N;
    for (int i = 0; i < N; i++) begin
      e.vld[i] = i < e.cnt;
      e.e[i] = '0;
      if (i < e.cnt) e.e[i] = mq[i];
    end
    exp_q.push_back(e);
    rst_n = rs;
    ib.ib_bundle_valid_i = v;
    ib.id_take_i = TW'(t);
    ib.ex_redirect_valid_i = r;
    @(posedge clk);
    #1;
    st = (D - mq.size()) < N;
    if (!rs || r) begin
      mq.delete();
      pc = addr_t'($urandom) & ~addr_t'(3);
      make_bundle();
    end else begin
      tk = t;
      if (tk > N) tk = N;
      if (tk > mq.size()) tk = mq.size();
      repeat (tk) void'(mq.pop_front());
      if (v && !st) begin
        for (int i = 0; i < N; i++) mq.push_back(bundle[i]);
        pc = pc + addr_t'(4 * N);
        make_bundle();
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("count", 128'(ib.ib_count_o), 128'(x.cnt));
      chk("stall", 128'(ib.ib_stall_o), 128'(x.stall));
      chk("valid", 128'(ib.id_valid_o), 128'(x.vld));
      for (int i = 0; i < N; i++)
        if (x.vld[i]) chk($sformatf("entry%0d", i), 128'(ib.id_entry_o[i]), 128'(x.e[i]));
    end
  end

  initial begin
    rst_n = 0;
    ib.ib_bundle_valid_i = 0;
    ib.ex_redirect_valid_i = 0;
    ib.id_take_i = '0;
    pc = 32'h1000;
    make_bundle();
    repeat (2) @(posedge clk);
    #1;
    repeat (6) cyc(1, 0, 0, 1);
    cyc(1, 3, 0, 1);
    repeat (2) cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 3, 0, 1);
    repeat (20) cyc(1, 3, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 3, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 1);
    cyc(1, 3, 1, 1);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 1);
    cyc(1, 2, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (400)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3),
          $urandom_range(0, 29) == 0, $urandom_range(0, 49) != 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Circular FIFO between fetch and decode. Absorbs N-wide fetch bundles and presents up to N oldest instructions per cycle to decode in program order. Backpressures fetch through a stall signal. Empties in one cycle on an EX/ROB redirect.

## Interface
- N, default `N: bundle width. Enqueue and dequeue are at most N entries per cycle.
- DEPTH, default 16: entry count. Must be a power of two and ≥ 2*N.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; state clears on the clock edge when reset==0
- ib_bundle_valid_i  in  1  fetch presents a full N-lane bundle this cycle
- ib_fetch_i  in  N×FETCH_ENTRY  bundle lanes; lane 0 is the oldest
- ib_stall_o  out  1  fetch must not enqueue this cycle
- ex_redirect_valid_i  in  1  flush the whole buffer
- id_valid_o  out  N  lane i holds a valid entry (thermometer mask)
- id_entry_o  out  N×FETCH_ENTRY  head..head+N-1 entries; lane 0 is the oldest
- id_take_i  in  $clog2(N+1)  number of lanes decode consumes this cycle
- ib_count_o  out  $clog2(DEPTH+1)  current occupancy (debug/perf)

## Operation
- State: storage array entries[DEPTH], head_ptr and tail_ptr (log2 DEPTH bits each, wrap modulo DEPTH), count (0..DEPTH).
- ib_stall_o = (DEPTH − count) < N. Computed from the registered count only. Same-cycle dequeue does not relieve stall. No combinational path from id_take_i.
- Enqueue fires when ib_bundle_valid_i && !ib_stall_o && !ex_redirect_valid_i.
  - All N lanes are written at tail..tail+N-1 (mod DEPTH).
  - tail advances by N.
  - There is no partial enqueue.
- Dequeue: take = min(id_take_i, count, N). Head advances by take. A request exceeding valid entries is clamped, never underflows.
- id_valid_o[i] = (i < count). id_entry_o[i] = entries[(head+i) mod DEPTH]. The read is combinational from registers. Invalid lanes carry stale data, which decode must ignore.
- Occupancy update: count_next = count + (enq ? N : 0) − take. Simultaneous enqueue and dequeue are legal, including at full−N and at empty.
- Flush (ex_redirect_valid_i=1):
  - head, tail and count are all zeroed.
  - Enqueue and dequeue in that cycle are discarded.
  - Flush takes priority over everything except reset.
- Branch metadata (is_branch, bp_pred_*, bp_ghr_snapshot) passes through unmodified.
- Reset (reset==0) is identical to flush and has priority over it. Array contents are not cleared.

## Timing
- Reset values: id_valid_o = 0, ib_count_o = 0, ib_stall_o = 0. id_entry_o is don't-care.
- Enqueue-to-visible latency is 1 cycle. An entry enqueued at edge k is visible on id_entry_o in cycle k+1. There is no bypass while empty.
- Dequeue takes effect at the edge. The next head lanes appear the following cycle.
- Flush is asserted in cycle k. In cycle k+1: id_valid_o = 0, ib_stall_o = 0.
- Pointer wrap: tail+N crossing DEPTH wraps with no bubble. A bundle may straddle the wrap boundary.
- Full: count = DEPTH gives stall = 1. The buffer still dequeues normally.
- Throughput: N per cycle in steady state when decode takes N each cycle and count ≤ DEPTH−N.

## Structure
- FETCH_ENTRY, ADDR and `N come from sys_defs.svh. No new typedefs are needed.
- Add `IB_DEPTH (default 16) to sys_defs.svh. The top level instantiates with DEPTH=`IB_DEPTH.
- Single module, no sub-modules. The storage array is flops (an SRAM macro is not justified at this size).
- Pointer arithmetic is done in pointer width and relies on natural overflow for the wrap. An assertion checks that DEPTH is a power of two.

## Test plan
All scenarios use N=3, DEPTH=16.
1. Reset, then 5 back-to-back bundles with id_take_i=0. Required: count goes 3, 6, 9, 12, 15. ib_stall_o=1 once count=15 (free 1 < 3). The 6th bundle is not accepted.
2. Fill to 15, then id_take_i=3 for one cycle with ib_bundle_valid_i held. Required: count becomes 12. Stall drops the next cycle. The bundle is accepted the cycle after, giving count 15.
3. Steady state with enqueue every cycle and id_take_i=3. Required: count constant at 3. PCs emerge in order through at least 3 pointer wraps. Bundles straddle entry 15→0 intact.
4. count=2, id_take_i=3. Required: take clamps to 2, count becomes 0, id_valid_o becomes 000. No underflow; head equals tail.
5. count=9 with simultaneous enqueue, take=3 and ex_redirect_valid_i=1. Required: the next cycle count=0, id_valid_o=000, ib_stall_o=0. The discarded bundle never appears.
6. Drive reset=0 mid-stream with count=7. Required: the next cycle all outputs are at reset values. The first post-reset bundle appears at lanes 0-2 with correct PCs and bp metadata intact.
